// File: rtl/map_pkg.sv
// Shared map geometry and cell types for the DDA FSMs, the map BROM wrapper
// and the map request server.
package map_pkg;
  localparam int N         = 24;
  localparam int MAP_CELLS = N * N;
  localparam int ADDR_W    = $clog2(MAP_CELLS);
  localparam int CELL_W    = 4;

  typedef logic [ADDR_W-1:0] map_addr_t;
  typedef logic [CELL_W-1:0] map_cell_t;

  localparam map_cell_t OOB_VALUE = 4'hF;

  // One extra bit so the limit stays correct even if MAP_CELLS is a power of two.
  localparam logic [ADDR_W:0] CELL_LIMIT = MAP_CELLS[ADDR_W:0];

  function automatic logic addr_is_oob(input map_addr_t a);
    return {1'b0, a} >= CELL_LIMIT;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first eligible port after `pointer`
// (with wrap-around) wins; the pointer register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(pointer) + k) % NUM_REQ);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/map_request_server.sv
// Round-robin server for single-cycle map reads from the DDA FSM array onto one
// BRAM port; responses return in grant order with a one-cycle one-hot valid.
module map_request_server
  import map_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        map_request_in,
  input  logic [NUM_REQ*ADDR_W-1:0] map_addra_in,
  output map_cell_t                 map_data_out,
  output logic [NUM_REQ-1:0]        map_data_valid_out,
  output map_addr_t                 bram_addr_out,
  output logic                      bram_en_out,
  input  map_cell_t                 bram_data_in,
  output logic                      overrun_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] id;
    logic             oob;
  } slot_t;

  logic [NUM_REQ-1:0] pending;
  map_addr_t          pend_addr [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  map_addr_t          grant_addr;
  logic               grant_oob;

  slot_t iss_slot;
  slot_t pipe [BRAM_LATENCY];
  slot_t tail;

  assign eligible = pending | map_request_in;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible    (eligible),
    .pointer     (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A pending request is older than one arriving this cycle, so it is served first.
  always_comb begin
    grant_addr = pending[grant_idx] ? pend_addr[grant_idx]
                                    : map_addra_in[grant_idx*ADDR_W +: ADDR_W];
    grant_oob  = addr_is_oob(grant_addr);
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending     <= '0;
      overrun_out <= 1'b0;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) pend_addr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (map_request_in[i]) pend_addr[i] <= map_addra_in[i*ADDR_W +: ADDR_W];
        if (grant[i]) pending[i] <= pending[i] & map_request_in[i];
        else          pending[i] <= pending[i] | map_request_in[i];
      end
      if (|(pending & map_request_in & ~grant)) overrun_out <= 1'b1;
      if (grant_valid) rr_ptr <= grant_idx;
    end
  end

  // Issue stage: an OOB slot travels down the pipe but never touches the BRAM.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      bram_en_out   <= 1'b0;
      bram_addr_out <= '0;
      iss_slot      <= '0;
    end else begin
      bram_en_out <= grant_valid && !grant_oob;
      if (grant_valid && !grant_oob) bram_addr_out <= grant_addr;
      iss_slot <= '{valid: grant_valid, id: grant_idx, oob: grant_oob};
    end
  end

  assign tail = pipe[BRAM_LATENCY-1];

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < BRAM_LATENCY; k++) pipe[k] <= '0;
      map_data_out       <= '0;
      map_data_valid_out <= '0;
    end else begin
      pipe[0] <= iss_slot;
      for (int k = 1; k < BRAM_LATENCY; k++) pipe[k] <= pipe[k-1];
      if (tail.valid) begin
        map_data_out       <= tail.oob ? OOB_VALUE : bram_data_in;
        map_data_valid_out <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tail.id;
      end else begin
        map_data_valid_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_map_request_server.sv
// Self-checking bench for map_request_server: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_map_request_server;
  import map_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 2;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in;
  logic [3:0]  map_request_in;
  logic [39:0] map_addra_in;
  map_cell_t   map_data_out;
  logic [3:0]  map_data_valid_out;
  map_addr_t   bram_addr_out;
  logic        bram_en_out;
  map_cell_t   bram_data_in;
  logic        overrun_out;

  map_request_server #(.NUM_REQ(NUM_REQ), .BRAM_LATENCY(LAT)) dut (
    .pixel_clk_in       (pixel_clk_in),
    .rst_in             (rst_in),
    .map_request_in     (map_request_in),
    .map_addra_in       (map_addra_in),
    .map_data_out       (map_data_out),
    .map_data_valid_out (map_data_valid_out),
    .bram_addr_out      (bram_addr_out),
    .bram_en_out        (bram_en_out),
    .bram_data_in       (bram_data_in),
    .overrun_out        (overrun_out)
  );

  // clock / BRAM behavioural model (two-cycle read latency)
  always #5 pixel_clk_in = ~pixel_clk_in;

  map_cell_t mem [1024];
  map_cell_t bram_d1;
  always @(posedge pixel_clk_in) begin
    bram_d1      <= mem[bram_addr_out];
    bram_data_in <= bram_d1;
  end

  // reference model: latest unserved address per port, rotating priority
  bit          m_pend [4];
  int          m_addr [4];
  int          m_ptr;
  bit          m_overrun;
  logic [9:0]  m_bram_addr;
  bit          m_bram_en;
  logic [3:0]  m_data;
  logic [7:0]  exp_q[$];   // {valid_onehot, data} for each future output cycle

  int checks = 0;
  int failures = 0;
  logic [3:0] obs_valid;
  logic [3:0] obs_data;
  logic [9:0] obs_addr;
  logic       obs_en;

  function automatic logic [39:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0;
      m_addr[i] = 0;
    end
    m_ptr       = 3;
    m_overrun   = 1'b0;
    m_bram_addr = '0;
    m_bram_en   = 1'b0;
    m_data      = '0;
    exp_q.delete();
    repeat (LAT + 1) exp_q.push_back(8'h00);
  endtask

  task automatic do_reset();
    rst_in         = 1'b1;
    map_request_in = '0;
    map_addra_in   = '0;
    repeat (2) @(posedge pixel_clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  // Applies one cycle of requests, advances one clock and checks every output.
  task automatic drive_cycle(input logic [3:0] req, input logic [39:0] addrs);
    int g;
    int ga;
    bit oob;
    logic [7:0] e;
    logic [7:0] got_e;
    map_request_in = req;
    map_addra_in   = addrs;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (m_ptr + k) % 4;
      if (g < 0 && (m_pend[p] || req[p])) g = p;
    end
    e = 8'h00;
    if (g >= 0) begin
      ga = m_pend[g] ? m_addr[g] : int'(addrs[g*10 +: 10]);
      m_ptr = g;
      oob = (ga >= MAP_CELLS);
      m_bram_en = !oob;
      if (!oob) m_bram_addr = 10'(ga);
      e = {4'(1 << g), oob ? 4'hF : mem[ga]};
    end else begin
      m_bram_en = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (req[i] && m_pend[i] && i != g) m_overrun = 1'b1;
      if (i == g) m_pend[i] = m_pend[i] && req[i];
      else        m_pend[i] = m_pend[i] || req[i];
      if (req[i]) m_addr[i] = int'(addrs[i*10 +: 10]);
    end
    exp_q.push_back(e);

    @(posedge pixel_clk_in);
    #1;
    got_e = exp_q.pop_front();
    if (got_e[7:4] != 4'h0) m_data = got_e[3:0];
    obs_valid = map_data_valid_out;
    obs_data  = map_data_out;
    obs_addr  = bram_addr_out;
    obs_en    = bram_en_out;

    checks++;
    if (bram_en_out !== m_bram_en) begin
      failures++;
      $display("FAIL bram_en t=%0t got=%0b exp=%0b", $time, bram_en_out, m_bram_en);
    end
    checks++;
    if (bram_addr_out !== m_bram_addr) begin
      failures++;
      $display("FAIL bram_addr t=%0t got=%0d exp=%0d", $time, bram_addr_out, m_bram_addr);
    end
    checks++;
    if (overrun_out !== m_overrun) begin
      failures++;
      $display("FAIL overrun t=%0t got=%0b exp=%0b", $time, overrun_out, m_overrun);
    end
    checks++;
    if (map_data_valid_out !== got_e[7:4]) begin
      failures++;
      $display("FAIL valid t=%0t got=%b exp=%b", $time, map_data_valid_out, got_e[7:4]);
    end
    checks++;
    if (map_data_out !== m_data) begin
      failures++;
      $display("FAIL data t=%0t got=%h exp=%h", $time, map_data_out, m_data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(4'b0000, 40'd0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({map_data_out, map_data_valid_out, bram_addr_out, bram_en_out, overrun_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got data=%h valid=%b addr=%0d en=%b ovr=%b exp=all zero",
               map_data_out, map_data_valid_out, bram_addr_out, bram_en_out, overrun_out);
    end
    idle(6);
  endtask

  task automatic test_single();
    do_reset();
    drive_cycle(4'b0010, pack4(0, 25, 0, 0));
    checks++;
    if (obs_addr !== 10'd25 || obs_en !== 1'b1) begin
      failures++;
      $display("FAIL single_issue got addr=%0d en=%b exp addr=25 en=1", obs_addr, obs_en);
    end
    for (int c = 2; c <= 4; c++) begin
      drive_cycle(4'b0000, 40'd0);
      checks++;
      if (obs_valid !== ((c == 4) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL single_valid cycle=%0d got=%b", c, obs_valid);
      end
    end
    checks++;
    if (obs_data !== 4'd3) begin
      failures++;
      $display("FAIL single_data got=%h exp=3", obs_data);
    end
    idle(3);
  endtask

  task automatic test_all_ports();
    logic [3:0] exp_v;
    do_reset();
    drive_cycle(4'b1111, pack4(0, 1, 2, 3));
    idle(2);
    for (int c = 4; c <= 7; c++) begin
      drive_cycle(4'b0000, 40'd0);
      exp_v = 4'(1 << (c - 4));
      checks++;
      if (obs_valid !== exp_v || obs_data !== 4'(c + 1)) begin
        failures++;
        $display("FAIL all_ports cycle=%0d got valid=%b data=%0d exp valid=%b data=%0d",
                 c, obs_valid, obs_data, exp_v, c + 1);
      end
    end
    idle(2);
  endtask

  task automatic test_oob();
    do_reset();
    drive_cycle(4'b1000, pack4(0, 0, 0, MAP_CELLS));
    checks++;
    if (obs_en !== 1'b0) begin
      failures++;
      $display("FAIL oob_en got=%b exp=0", obs_en);
    end
    idle(3);
    checks++;
    if (obs_valid !== 4'b1000 || obs_data !== 4'hF) begin
      failures++;
      $display("FAIL oob_resp got valid=%b data=%h exp valid=1000 data=f", obs_valid, obs_data);
    end
    idle(2);
  endtask

  task automatic test_overrun();
    int n_resp;
    logic [3:0] last_d;
    do_reset();
    drive_cycle(4'b0010, pack4(0, 40, 0, 0));   // leaves the pointer on port 1
    idle(5);
    checks++;
    if (overrun_out !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pre got=%b exp=0", overrun_out);
    end
    drive_cycle(4'b1111, pack4(200, 10, 202, 203));
    drive_cycle(4'b0010, pack4(0, 11, 0, 0));
    checks++;
    if (overrun_out !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b exp=1", overrun_out);
    end
    n_resp = 0;
    last_d = '0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(4'b0000, 40'd0);
      if (obs_valid === 4'b0010) begin
        n_resp++;
        last_d = obs_data;
      end
    end
    checks++;
    if (n_resp != 1 || last_d !== mem[11]) begin
      failures++;
      $display("FAIL overrun_resp got count=%0d data=%h exp count=1 data=%h", n_resp, last_d, mem[11]);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(4'b0101, pack4(100, 0, 102, 0));
      checks++;
      if (obs_addr !== ((i % 2 == 0) ? 10'd100 : 10'd102)) begin
        failures++;
        $display("FAIL fair_alt step=%0d got=%0d exp=%0d", i, obs_addr, (i % 2 == 0) ? 100 : 102);
      end
    end
    drive_cycle(4'b1001, pack4(110, 0, 0, 113));
    checks++;
    if (obs_addr !== 10'd113) begin
      failures++;
      $display("FAIL fair_contest got=%0d exp=113", obs_addr);
    end
    idle(8);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive_cycle(4'b0011, pack4(5, 6, 0, 0));
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if ({map_data_out, map_data_valid_out, bram_addr_out, bram_en_out, overrun_out} !== '0) begin
      failures++;
      $display("FAIL async_reset got data=%h valid=%b addr=%0d en=%b exp=all zero",
               map_data_out, map_data_valid_out, bram_addr_out, bram_en_out);
    end
    do_reset();
    idle(6);
    drive_cycle(4'b0101, pack4(7, 0, 9, 0));
    idle(3);
    checks++;
    if (obs_valid !== 4'b0001 || obs_data !== mem[7]) begin
      failures++;
      $display("FAIL post_reset got valid=%b data=%h exp valid=0001 data=%h", obs_valid, obs_data, mem[7]);
    end
    idle(5);
  endtask

  task automatic test_random();
    logic [39:0] a;
    logic [3:0]  r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) a[i*10 +: 10] = 10'($urandom_range(0, 599));
      drive_cycle(r, a);
    end
    idle(10);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[25] = 4'd3;
    mem[0] = 4'd5; mem[1] = 4'd6; mem[2] = 4'd7; mem[3] = 4'd8;
    mem[10] = 4'd1; mem[11] = 4'd9;
    model_reset();

    test_reset();
    test_single();
    test_all_ports();
    test_oob();
    test_overrun();
    test_fairness();
    test_reset_midflight();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/map_request_server.md
Name: map_request_server

Overview:
- Responder end of the map-read handshake that the DDA FSMs initiate.
- Accepts single-cycle map requests from NUM_REQ DDA FSMs and arbitrates them round-robin onto one map BRAM read port.
- Tracks BRAM read latency and returns each cell value with a one-cycle valid pulse to the originating requester.
- Sits between the parallel DDA FSM array and the map BROM.

Parameters:
- NUM_REQ, 4, number of DDA FSM requesters.
- N, 24, map side length; map holds N*N cells.
- ADDR_W, $clog2(N*N) (10), map address width.
- BRAM_LATENCY, 2, cycles from bram_addr_out change to matching bram_data_in.
- OOB_VALUE, 4'hF, cell value returned for out-of-range addresses.

Ports:
- pixel_clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-high.
- map_request_in  in  NUM_REQ  bit i pulses for one cycle when requester i issues a read.
- map_addra_in  in  NUM_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W]; valid when bit i of map_request_in is high.
- map_data_out  out  4  returned cell value, broadcast to all requesters.
- map_data_valid_out  out  NUM_REQ  one-hot, single-cycle; bit i means map_data_out belongs to requester i.
- bram_addr_out  out  ADDR_W  BRAM read address.
- bram_en_out  out  1  BRAM read enable.
- bram_data_in  in  4  BRAM read data.
- overrun_out  out  1  sticky flag; a requester re-requested while its previous request was still ungranted.

Behaviour:
- Reset (async assert):
  - Outputs: map_data_out=0, map_data_valid_out=0, bram_addr_out=0, bram_en_out=0, overrun_out=0.
  - Internal: all pending bits, pending addresses and pipeline stages clear; rr pointer = NUM_REQ-1, so port 0 wins first.
  - Reset mid-operation discards in-flight reads. No valid pulse is emitted for them.
- Capture:
  - Per port, a pending bit plus an address register.
  - map_request_in[i] high sets pending[i] and loads the address.
  - If pending[i] is already set and not granted that cycle: the address is overwritten, pending stays set, overrun_out is set (sticky until reset).
- Arbitration:
  - eligible = pending | map_request_in, so a request can be granted in the same cycle it arrives.
  - Grant goes to the first eligible port searching from rr_pointer+1 with wrap-around; rr_pointer then updates to the granted port.
  - At most one grant per cycle.
  - The granted port's pending bit clears, unless a new request on that port arrives the same cycle. In that case the new request becomes pending, and it is not an overrun.
- Issue (registered):
  - On a grant: bram_en_out<=1 and bram_addr_out<=granted address.
  - Otherwise bram_en_out<=0 and bram_addr_out holds its value.
  - Address >= N*N is OOB: bram_en_out<=0, but the slot still occupies the pipeline.
- Pipeline:
  - Shift register of depth BRAM_LATENCY carrying {valid, port id, oob} in step with the BRAM read.
  - At the tail, registered: map_data_out <= oob ? OOB_VALUE : bram_data_in, and map_data_valid_out <= one-hot(id) when valid, else 0.
  - map_data_out holds its last value when there is no valid.
- Latency:
  - Uncontended, request high in cycle 0 gives bram_addr_out in cycle 1 and map_data_valid_out in cycle BRAM_LATENCY+2 (cycle 4 at default).
  - Each contending port adds one cycle per port granted ahead of it.
- Throughput:
  - One read per cycle, fully pipelined.
  - Responses return in grant order.
  - Worst-case wait per port is NUM_REQ-1 cycles.
- A requester re-requesting while its previous read is in flight (granted, not returned) is legal. The responses return in order.
- No backpressure: requesters must accept valid whenever it arrives.

Decomposition:
- Package map_pkg:
  - Constants N, MAP_CELLS=N*N, ADDR_W, CELL_W=4, OOB_VALUE.
  - Typedef map_addr_t (ADDR_W bits) and map_cell_t (CELL_W bits), shared with the DDA FSMs and the map BROM wrapper.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Takes an eligible vector and the pointer; returns a one-hot grant and a grant index.
  - Purely combinational. The pointer register stays in map_request_server.

Test Plan:
- Single request, port 1, address 25 (BRAM cell=3), request in cycle 0 -> bram_addr_out=25 in cycle 1; map_data_valid_out=4'b0010 and map_data_out=3 in cycle 4; no other valid bits.
- All 4 ports request in the same cycle, addresses 0/1/2/3 with cells 5/6/7/8 -> valids 0001,0010,0100,1000 in cycles 4,5,6,7 with data 5,6,7,8.
- Fairness:
  - Ports 0 and 2 request back-to-back continuously -> grants alternate 0,2,0,2 and neither port misses two consecutive turns.
  - After a port-2 grant, a new port-0/3 contest -> port 3 wins first.
- OOB: port 3 requests address 576 (=N*N) -> bram_en_out stays 0; map_data_out=4'hF with valid 1000 in cycle 4.
- Overrun: hold port 1 off grant behind ports 0, 2 and 3, then pulse port 1 twice with addresses 10 then 11 -> overrun_out=1; a single response for address 11 only.
- Reset mid-flight: assert rst_in one cycle after a grant -> outputs zero immediately (asynchronous); no valid pulse after reset release; the next request has normal latency with port 0 preferred.
